debounce_onepulse_vector: RTL and testbench



---
 rtl/debounce_onepulse_vector.sv | 120 ++++++++++++
 tb/tb_debounce_onepulse_vector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/debounce_onepulse_vector.sv
// rtl/debounce_onepulse_vector.sv - per-channel sync, debounce, edge pulse and auto-repeat
//
// Conditions a vector of active-low push-button/switch inputs. Each channel is
// synchronised (2 FF), debounced by a consecutive-sample counter, and emits a
// registered one-cycle active-low pulse on press, release or both, optionally
// auto-repeating while held.
//
// Ports:
//   clk_op               in   1      operating clock, rising edge
//   reset                in   1      asynchronous, active-high, clears all state
//   signals_n            in   W      raw active-low inputs (0 = pressed), async to clk_op
//   signals_onepulsed_n  out  W      registered active-low one-cycle pulses
//   signals_debounced_n  out  W      registered active-low debounced level

module debounce_onepulse_vector #(
  parameter int SIGNAL_BIT_WIDTH = 1,
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int EDGE_MODE        = 0,
  parameter int REPEAT_EN        = 0,
  parameter int REPEAT_DELAY     = 8,
  parameter int REPEAT_PERIOD    = 4
) (
  input  logic                        clk_op,
  input  logic                        reset,
  input  logic [SIGNAL_BIT_WIDTH-1:0] signals_n,
  output logic [SIGNAL_BIT_WIDTH-1:0] signals_onepulsed_n,
  output logic [SIGNAL_BIT_WIDTH-1:0] signals_debounced_n
);

  localparam int W    = SIGNAL_BIT_WIDTH;
  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] DC_MAX  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LOAD = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LOAD = RW'(REPEAT_PERIOD - 1);

  localparam bit PRESS_ON = (EDGE_MODE == 0) || (EDGE_MODE == 2);
  localparam bit REL_ON   = (EDGE_MODE == 1) || (EDGE_MODE == 2);
  // Repeat only makes sense when presses generate pulses.
  localparam bit REP_ON   = (REPEAT_EN != 0) && (EDGE_MODE != 1);

  logic [W-1:0]  r_sync1;
  logic [W-1:0]  r_sync2;
  logic [W-1:0]  r_deb;      // 1 = pressed
  logic [W-1:0]  r_pulse_n;
  logic [DW-1:0] r_dcnt [W];
  logic [RW-1:0] r_rcnt [W];

  logic [W-1:0]  w_raw;      // synchronised input, 1 = pressed
  logic [W-1:0]  w_flip;
  logic [W-1:0]  w_press_flip;
  logic [W-1:0]  w_rel_flip;
  logic [W-1:0]  w_rep;
  logic [W-1:0]  w_event;

  assign w_raw = ~r_sync2;

  always_comb begin
    w_flip       = '0;
    w_press_flip = '0;
    w_rel_flip   = '0;
    w_rep        = '0;
    w_event      = '0;
    for (int i = 0; i < W; i++) begin
      w_flip[i]       = (w_raw[i] != r_deb[i]) && (r_dcnt[i] == DC_MAX);
      w_press_flip[i] = w_flip[i] & w_raw[i];
      w_rel_flip[i]   = w_flip[i] & ~w_raw[i];
      // A flip on the same edge (only a release is possible while held)
      // takes precedence over a due repeat.
      w_rep[i]        = REP_ON && r_deb[i] && !w_flip[i] && (r_rcnt[i] == '0);
      w_event[i]      = (PRESS_ON && w_press_flip[i]) ||
                        (REL_ON && w_rel_flip[i]) ||
                        w_rep[i];
    end
  end

  always_ff @(posedge clk_op or posedge reset) begin
    if (reset) begin
      r_sync1   <= '1;
      r_sync2   <= '1;
      r_deb     <= '0;
      r_pulse_n <= '1;
      for (int i = 0; i < W; i++) begin
        r_dcnt[i] <= '0;
        r_rcnt[i] <= '0;
      end
    end else begin
      r_sync1   <= signals_n;
      r_sync2   <= r_sync1;
      r_pulse_n <= ~w_event;
      for (int i = 0; i < W; i++) begin
        // Any agreeing sample restarts the count, rejecting short glitches.
        if (w_raw[i] == r_deb[i]) begin
          r_dcnt[i] <= '0;
        end else if (w_flip[i]) begin
          r_deb[i]  <= w_raw[i];
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + DW'(1);
        end

        if (w_press_flip[i]) begin
          r_rcnt[i] <= RD_LOAD;
        end else if (r_deb[i] && !w_flip[i]) begin
          if (r_rcnt[i] == '0) begin
            r_rcnt[i] <= RP_LOAD;
          end else begin
            r_rcnt[i] <= r_rcnt[i] - RW'(1);
          end
        end
      end
    end
  end

  assign signals_onepulsed_n = r_pulse_n;
  assign signals_debounced_n = ~r_deb;

endmodule

// File: tb/tb_debounce_onepulse_vector.sv
// tb/tb_debounce_onepulse_vector.sv - scoreboard bench for debounce_onepulse_vector
module tb_debounce_onepulse_vector;

  localparam int W   = 4;
  localparam int DC  = 4;
  // Input driven at the falling edge after edge n is captured at n+1 and
  // flips the debounced level at n+1+1+DC.
  localparam int LAT = DC + 2;

  logic         clk_op = 1'b0;
  logic         reset;
  logic [W-1:0] sig_a, sig_b, sig_c;
  logic [W-1:0] op_a, db_a, op_b, db_b, op_c, db_c;
  logic [W-1:0] prev_db_a = '1, prev_db_b = '1, prev_db_c = '1;

  int edge_no = 0;
  int errors  = 0;
  int checks  = 0;
  int p;

  typedef struct {
    int           edge_n;
    logic [W-1:0] op;
    logic [W-1:0] db;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  // press pulses only
  debounce_onepulse_vector #(
    .SIGNAL_BIT_WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(0),
    .REPEAT_EN(0), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
  ) u_a (
    .clk_op(clk_op), .reset(reset), .signals_n(sig_a),
    .signals_onepulsed_n(op_a), .signals_debounced_n(db_a)
  );

  // release pulses only
  debounce_onepulse_vector #(
    .SIGNAL_BIT_WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(1),
    .REPEAT_EN(0), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
  ) u_b (
    .clk_op(clk_op), .reset(reset), .signals_n(sig_b),
    .signals_onepulsed_n(op_b), .signals_debounced_n(db_b)
  );

  // both edges with auto-repeat
  debounce_onepulse_vector #(
    .SIGNAL_BIT_WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(2),
    .REPEAT_EN(1), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
  ) u_c (
    .clk_op(clk_op), .reset(reset), .signals_n(sig_c),
    .signals_onepulsed_n(op_c), .signals_debounced_n(db_c)
  );

  always #5 clk_op = ~clk_op;

  always @(posedge clk_op) edge_no <= edge_no + 1;

  function automatic void push_exp(input int id, input int e,
                                   input logic [W-1:0] op, input logic [W-1:0] db);
    exp_t x;
    x.edge_n = e;
    x.op     = op;
    x.db     = db;
    case (id)
      0:       q_a.push_back(x);
      1:       q_b.push_back(x);
      default: q_c.push_back(x);
    endcase
  endfunction

  task automatic mon(input int id, input logic [W-1:0] op, input logic [W-1:0] db);
    exp_t x;
    bit   have;
    have = 1'b0;
    x    = '{0, '1, '1};
    case (id)
      0:       if (q_a.size() > 0) begin x = q_a.pop_front(); have = 1'b1; end
      1:       if (q_b.size() > 0) begin x = q_b.pop_front(); have = 1'b1; end
      default: if (q_c.size() > 0) begin x = q_c.pop_front(); have = 1'b1; end
    endcase
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL unexpected_event dut%0d: got edge=%0d op=%b db=%b, required no event",
               id, edge_no, op, db);
    end else if (x.edge_n != edge_no || x.op != op || x.db != db) begin
      errors++;
      $display("FAIL event dut%0d: got edge=%0d op=%b db=%b, required edge=%0d op=%b db=%b",
               id, edge_no, op, db, x.edge_n, x.op, x.db);
    end
  endtask

  // An output event is any pulse or any change of the debounced level.
  always @(negedge clk_op) begin
    if (op_a != '1 || db_a != prev_db_a) mon(0, op_a, db_a);
    if (op_b != '1 || db_b != prev_db_b) mon(1, op_b, db_b);
    if (op_c != '1 || db_c != prev_db_c) mon(2, op_c, db_c);
    prev_db_a = db_a;
    prev_db_b = db_b;
    prev_db_c = db_c;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_op);
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic drain(input int id, input exp_t x);
    checks++;
    errors++;
    $display("FAIL missing_event dut%0d: required edge=%0d op=%b db=%b",
             id, x.edge_n, x.op, x.db);
  endtask

  initial begin
    reset = 1'b1;
    sig_a = '1;
    sig_b = '1;
    sig_c = '1;
    step(3);
    reset = 1'b0;

    // Idle after reset: nothing moves.
    step(50);
    chk("idle_op_a", op_a, 4'b1111);
    chk("idle_db_a", db_a, 4'b1111);
    chk("idle_op_b", op_b, 4'b1111);
    chk("idle_db_c", db_c, 4'b1111);

    // Clean press on ch0, release gives no pulse in press mode.
    sig_a[0] = 1'b0;
    push_exp(0, edge_no + LAT, 4'b1110, 4'b1110);
    step(20);
    sig_a[0] = 1'b1;
    push_exp(0, edge_no + LAT, 4'b1111, 4'b1111);
    step(15);

    // Bounce on ch1: 3 low / 1 high never reaches 4 agreeing samples.
    for (int r = 0; r < 5; r++) begin
      sig_a[1] = 1'b0;
      step(3);
      sig_a[1] = 1'b1;
      step(1);
    end
    sig_a[1] = 1'b0;
    push_exp(0, edge_no + LAT, 4'b1101, 4'b1101);
    step(20);
    sig_a[1] = 1'b1;
    push_exp(0, edge_no + LAT, 4'b1111, 4'b1111);
    step(15);

    // Auto-repeat on ch2; release lands on a due repeat edge (P+32).
    sig_c[2] = 1'b0;
    p = edge_no + LAT;
    push_exp(2, p, 4'b1011, 4'b1011);
    for (int k = 8; k <= 28; k += 4) push_exp(2, p + k, 4'b1011, 4'b1011);
    step(32);
    sig_c[2] = 1'b1;
    push_exp(2, p + 32, 4'b1011, 4'b1111);
    step(15);

    // Release mode: ch0 and ch3 together.
    sig_b[0] = 1'b0;
    sig_b[3] = 1'b0;
    push_exp(1, edge_no + LAT, 4'b1111, 4'b0110);
    step(20);
    sig_b = '1;
    push_exp(1, edge_no + LAT, 4'b0110, 4'b1111);
    step(15);

    // Asynchronous reset mid-hold, then a fresh press from the held input.
    sig_a[0] = 1'b0;
    push_exp(0, edge_no + LAT, 4'b1110, 4'b1110);
    step(10);
    @(posedge clk_op);
    #2;
    reset = 1'b1;
    push_exp(0, edge_no, 4'b1111, 4'b1111);
    #1;
    chk("async_reset_op_a", op_a, 4'b1111);
    chk("async_reset_db_a", db_a, 4'b1111);
    step(2);
    reset = 1'b0;
    push_exp(0, edge_no + LAT, 4'b1110, 4'b1110);
    step(20);
    sig_a[0] = 1'b1;
    push_exp(0, edge_no + LAT, 4'b1111, 4'b1111);
    step(15);

    while (q_a.size() > 0) drain(0, q_a.pop_front());
    while (q_b.size() > 0) drain(1, q_b.pop_front());
    while (q_c.size() > 0) drain(2, q_c.pop_front());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
